// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, FSM state type and sclk edge-selection helpers.
package spi_pkg;

  // Mode encoding is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

  function automatic logic leading_is_rise(input logic cpol);
    return ~cpol;
  endfunction

  // Sample on the leading edge for cpha=0, on the trailing edge for cpha=1
  function automatic logic sample_is_rise(input logic [1:0] mode);
    return mode[0] ? ~leading_is_rise(mode[1]) : leading_is_rise(mode[1]);
  endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Core-side stream and status bundle of the clk-synchronous SPI slave.
interface spi_slave_sync_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  tx_underrun;
  logic                  rx_overrun;
  logic                  frame_abort;
  logic                  busy;

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  rx_ready,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output tx_underrun,
    output rx_overrun,
    output frame_abort,
    output busy
  );

  modport master (
    output tx_data,
    output tx_valid,
    output rx_ready,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  tx_underrun,
    input  rx_overrun,
    input  frame_abort,
    input  busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses from
// the last stage against one extra history register.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_last  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_last  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync   = r_chain[SYNC_STAGES-1];
  assign o_rise_c = r_chain[SYNC_STAGES-1] & ~r_last;
  assign o_fall_c = ~r_chain[SYNC_STAGES-1] & r_last;

endmodule

// File: rtl/spi_slave_sync.sv
// System-clock-synchronous SPI slave: oversampled pins, runtime CPOL/CPHA,
// multi-word bursts per frame, valid/ready word streams to the core.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        UNDERRUN_FILL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic cpol,
  input  logic cpha,
  input  logic sclk,
  input  logic csb,
  input  logic din,
  output logic dout,
  output logic dout_oe,
  spi_slave_sync_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_csb_rise;
  logic w_csb_fall;
  logic w_din_sync;
  logic w_sclk_sync_unused;
  logic w_csb_sync_unused;
  logic w_din_rise_unused;
  logic w_din_fall_unused;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .i_d      (sclk),
    .o_sync   (w_sclk_sync_unused),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall)
  );

  // csb idles high so reset must not fabricate a frame start
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_csb_sync (
    .clk      (clk),
    .rst      (rst),
    .i_d      (csb),
    .o_sync   (w_csb_sync_unused),
    .o_rise_c (w_csb_rise),
    .o_fall_c (w_csb_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_din_sync (
    .clk      (clk),
    .rst      (rst),
    .i_d      (din),
    .o_sync   (w_din_sync),
    .o_rise_c (w_din_rise_unused),
    .o_fall_c (w_din_fall_unused)
  );

  spi_state_e            r_state,        w_state_n;
  logic [1:0]            r_mode,         w_mode_n;
  logic [CNT_W-1:0]      r_bit_cnt,      w_bit_cnt_n;
  logic [DATA_WIDTH-1:0] r_tx_sh,        w_tx_sh_n;
  logic [DATA_WIDTH-1:0] r_rx_sh,        w_rx_sh_n;
  logic [DATA_WIDTH-1:0] r_rx_data,      w_rx_data_n;
  logic                  r_first_shift,  w_first_shift_n;
  logic                  r_load_pending, w_load_pending_n;
  logic                  r_rx_valid,     w_rx_valid_n;
  logic                  r_tx_ready,     w_tx_ready_n;
  logic                  r_tx_underrun,  w_tx_underrun_n;
  logic                  r_rx_overrun,   w_rx_overrun_n;
  logic                  r_frame_abort,  w_frame_abort_n;
  logic                  r_busy,         w_busy_n;

  logic                  w_sample;
  logic                  w_shift;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_rx_word;
  logic [DATA_WIDTH-1:0] w_fill;

  // Map sclk edges onto sample/shift using the mode latched at frame start
  always_comb begin
    w_sample = sample_is_rise(r_mode) ? w_sclk_rise : w_sclk_fall;
    w_shift  = sample_is_rise(r_mode) ? w_sclk_fall : w_sclk_rise;
  end

  assign w_rx_word = {r_rx_sh[DATA_WIDTH-2:0], w_din_sync};
  assign w_fill    = {DATA_WIDTH{UNDERRUN_FILL}};

  always_comb begin
    w_state_n        = r_state;
    w_mode_n         = r_mode;
    w_bit_cnt_n      = r_bit_cnt;
    w_tx_sh_n        = r_tx_sh;
    w_rx_sh_n        = r_rx_sh;
    w_rx_data_n      = r_rx_data;
    w_first_shift_n  = r_first_shift;
    w_load_pending_n = r_load_pending;
    w_rx_valid_n     = r_rx_valid & ~bus.rx_ready;
    w_tx_ready_n     = 1'b0;
    w_tx_underrun_n  = 1'b0;
    w_rx_overrun_n   = 1'b0;
    w_frame_abort_n  = 1'b0;
    w_busy_n         = r_busy;
    w_load           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_csb_fall) begin
          w_state_n        = ST_ACTIVE;
          w_busy_n         = 1'b1;
          w_mode_n         = spi_mode(cpol, cpha);
          w_bit_cnt_n      = '0;
          w_first_shift_n  = cpha;
          w_load_pending_n = 1'b0;
          w_load           = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // csb release outranks any sclk edge landing in the same cycle
        if (w_csb_rise) begin
          w_state_n       = ST_IDLE;
          w_busy_n        = 1'b0;
          w_frame_abort_n = (r_bit_cnt != '0);
        end else if (w_sample) begin
          w_rx_sh_n = w_rx_word;
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_n      = '0;
            w_load_pending_n = 1'b1;
            w_rx_data_n      = w_rx_word;
            w_rx_valid_n     = 1'b1;
            w_rx_overrun_n   = r_rx_valid & ~bus.rx_ready;
          end else begin
            w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
          end
        end else if (w_shift) begin
          if (r_load_pending) begin
            w_load           = 1'b1;
            w_load_pending_n = 1'b0;
          end else if (r_first_shift) begin
            w_first_shift_n = 1'b0;
          end else begin
            w_tx_sh_n = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase

    // Word load: take core data if offered, otherwise the fill pattern
    if (w_load) begin
      if (bus.tx_valid) begin
        w_tx_sh_n    = bus.tx_data;
        w_tx_ready_n = 1'b1;
      end else begin
        w_tx_sh_n       = w_fill;
        w_tx_underrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_mode         <= 2'b00;
      r_bit_cnt      <= '0;
      r_tx_sh        <= '0;
      r_rx_sh        <= '0;
      r_rx_data      <= '0;
      r_first_shift  <= 1'b0;
      r_load_pending <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_tx_ready     <= 1'b0;
      r_tx_underrun  <= 1'b0;
      r_rx_overrun   <= 1'b0;
      r_frame_abort  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_mode         <= w_mode_n;
      r_bit_cnt      <= w_bit_cnt_n;
      r_tx_sh        <= w_tx_sh_n;
      r_rx_sh        <= w_rx_sh_n;
      r_rx_data      <= w_rx_data_n;
      r_first_shift  <= w_first_shift_n;
      r_load_pending <= w_load_pending_n;
      r_rx_valid     <= w_rx_valid_n;
      r_tx_ready     <= w_tx_ready_n;
      r_tx_underrun  <= w_tx_underrun_n;
      r_rx_overrun   <= w_rx_overrun_n;
      r_frame_abort  <= w_frame_abort_n;
      r_busy         <= w_busy_n;
    end
  end

  assign dout            = r_tx_sh[DATA_WIDTH-1];
  assign dout_oe         = r_busy;
  assign bus.busy        = r_busy;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.rx_overrun  = r_rx_overrun;
  assign bus.frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: table of full-frame exchanges in all modes
// plus hand sequences for overrun, partial-frame abort and mid-frame reset.
module tb_spi_slave_sync;
  import spi_pkg::*;

  localparam int unsigned DW   = 16;
  localparam int          HALF = 8;
  localparam int          NV   = 5;

  typedef struct packed {
    logic [1:0]          mode;
    int                  nw;
    logic [2:0][DW-1:0]  mosi;
    int                  txc;
    logic [3:0][DW-1:0]  tx;
    logic [2:0][DW-1:0]  miso;
    int                  etxr;
    int                  eund;
  } vec_t;

  logic clk = 1'b0;
  logic rst, cpol, cpha, sclk, csb, din, dout, dout_oe;

  spi_slave_sync_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_sync #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (2),
    .UNDERRUN_FILL (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cpol    (cpol),
    .cpha    (cpha),
    .sclk    (sclk),
    .csb     (csb),
    .din     (din),
    .dout    (dout),
    .dout_oe (dout_oe),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txr = 0, n_und = 0, n_ovr = 0, n_abt = 0, n_rx = 0;
  int tx_idx = 0, tx_cnt = 0;
  logic [DW-1:0] rx_got   [0:63];
  logic [DW-1:0] tx_words [0:7];
  logic [DW-1:0] miso_got [0:2];
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk cycle: sample DUT outputs on the falling edge, then update the TX feeder
  task automatic tick();
    @(negedge clk);
    if (bus.tx_ready) begin
      n_txr++;
      if (tx_idx < tx_cnt) tx_idx++;
    end
    if (bus.tx_underrun) n_und++;
    if (bus.rx_overrun)  n_ovr++;
    if (bus.frame_abort) n_abt++;
    if (bus.rx_valid && bus.rx_ready) begin
      if (n_rx < 64) rx_got[n_rx] = bus.rx_data;
      n_rx++;
    end
    bus.tx_valid = (tx_idx < tx_cnt);
    bus.tx_data  = tx_words[tx_idx % 8];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic set_tx(input logic [3:0][DW-1:0] t, input int c);
    for (int k = 0; k < 4; k++) tx_words[k] = t[k];
    tx_idx       = 0;
    tx_cnt       = c;
    bus.tx_valid = (c > 0);
    bus.tx_data  = tx_words[0];
  endtask

  // SPI master: nbits MSB-first across mosi words, MISO bits collected in miso_got
  task automatic spi_frame(input logic [1:0] mode, input int nbits,
                           input logic [2:0][DW-1:0] mosi, input bit hold);
    int w, b;
    for (int k = 0; k < 3; k++) miso_got[k] = '0;
    cpol = mode[1];
    cpha = mode[0];
    sclk = mode[1];
    wait_cyc(6);
    csb = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      w = i / DW;
      b = DW - 1 - (i % DW);
      if (mode[0] == 1'b0) begin
        din            = mosi[w][b];
        miso_got[w][b] = dout;
        sclk           = ~sclk;
        wait_cyc(HALF);
        sclk = ~sclk;
        wait_cyc(HALF);
      end else begin
        sclk = ~sclk;
        din  = mosi[w][b];
        wait_cyc(HALF);
        miso_got[w][b] = dout;
        sclk           = ~sclk;
        wait_cyc(HALF);
      end
    end
    if (!hold) begin
      csb = 1'b1;
      wait_cyc(2 * HALF);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input int nw,
                              input logic [DW-1:0] m0, m1, m2, input int txc,
                              input logic [DW-1:0] t0, t1, t2, t3,
                              input logic [DW-1:0] e0, e1, e2,
                              input int etxr, input int eund);
    vec_t v;
    v.mode = mode;  v.nw = nw;    v.txc = txc;
    v.mosi[0] = m0; v.mosi[1] = m1; v.mosi[2] = m2;
    v.tx[0] = t0;   v.tx[1] = t1;   v.tx[2] = t2;   v.tx[3] = t3;
    v.miso[0] = e0; v.miso[1] = e1; v.miso[2] = e2;
    v.etxr = etxr;  v.eund = eund;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_txr, b_und, b_ovr, b_abt, b_rx;
    logic [2:0][DW-1:0] mw;
    logic [DW-1:0] exp_hi;

    rst = 1'b1; csb = 1'b1; sclk = 1'b0; din = 1'b0; cpol = 1'b0; cpha = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.rx_ready = 1'b1;
    for (int k = 0; k < 8; k++) tx_words[k] = '0;

    vecs[0] = mk(SPI_MODE0, 1, 16'h1234, 16'h0, 16'h0, 2,
                 16'hA5C3, 16'h1111, 16'h0, 16'h0, 16'hA5C3, 16'h0, 16'h0, 2, 0);
    vecs[1] = mk(SPI_MODE1, 3, 16'h0001, 16'h8000, 16'hFFFF, 3,
                 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 3, 0);
    vecs[2] = mk(SPI_MODE2, 3, 16'h0001, 16'h8000, 16'hFFFF, 4,
                 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 4, 0);
    vecs[3] = mk(SPI_MODE3, 3, 16'h0001, 16'h8000, 16'hFFFF, 3,
                 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 3, 0);
    vecs[4] = mk(SPI_MODE1, 1, 16'h5A5A, 16'h0, 16'h0, 0,
                 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 0, 1);

    repeat (3) @(negedge clk);
    check("reset dout", dout, 1'b0);
    check("reset dout_oe", dout_oe, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset rx_valid", bus.rx_valid, 1'b0);
    check("reset rx_data", bus.rx_data, 16'h0);
    check("reset pulses", {bus.tx_ready, bus.tx_underrun, bus.rx_overrun, bus.frame_abort}, 4'b0);
    rst = 1'b0;
    wait_cyc(4);

    for (int v = 0; v < NV; v++) begin
      set_tx(vecs[v].tx, vecs[v].txc);
      b_txr = n_txr; b_und = n_und; b_ovr = n_ovr; b_abt = n_abt; b_rx = n_rx;
      spi_frame(vecs[v].mode, vecs[v].nw * DW, vecs[v].mosi, 1'b0);
      for (int k = 0; k < vecs[v].nw; k++) begin
        check($sformatf("v%0d miso word%0d", v, k), miso_got[k], vecs[v].miso[k]);
        check($sformatf("v%0d rx word%0d", v, k), rx_got[b_rx + k], vecs[v].mosi[k]);
      end
      check($sformatf("v%0d rx count", v), n_rx - b_rx, vecs[v].nw);
      check($sformatf("v%0d tx_ready count", v), n_txr - b_txr, vecs[v].etxr);
      check($sformatf("v%0d underrun count", v), n_und - b_und, vecs[v].eund);
      check($sformatf("v%0d overrun count", v), n_ovr - b_ovr, 0);
      check($sformatf("v%0d abort count", v), n_abt - b_abt, 0);
    end

    // Overrun: consumer stalls across a 2-word burst
    set_tx({16'h0, 16'h3333, 16'h2222, 16'h1111}, 3);
    bus.rx_ready = 1'b0;
    b_ovr = n_ovr; b_rx = n_rx; b_und = n_und;
    mw = '0; mw[0] = 16'h0F0F; mw[1] = 16'hF0F0;
    spi_frame(SPI_MODE0, 2 * DW, mw, 1'b0);
    check("ovr miso word0", miso_got[0], 16'h1111);
    check("ovr miso word1", miso_got[1], 16'h2222);
    check("ovr overrun count", n_ovr - b_ovr, 1);
    check("ovr rx_valid held", bus.rx_valid, 1'b1);
    check("ovr rx_data", bus.rx_data, 16'hF0F0);
    check("ovr underrun count", n_und - b_und, 0);
    bus.rx_ready = 1'b1;
    wait_cyc(2);
    check("ovr rx_valid cleared", bus.rx_valid, 1'b0);

    // Abort after 7 bits, then a clean frame
    set_tx({16'h0, 16'h9999, 16'h8888, 16'h7777}, 3);
    b_abt = n_abt; b_rx = n_rx;
    mw = '0; mw[0] = 16'hABCD;
    spi_frame(SPI_MODE0, 7, mw, 1'b0);
    exp_hi = 16'h7777;
    check("abort count", n_abt - b_abt, 1);
    check("abort rx count", n_rx - b_rx, 0);
    check("abort rx_valid", bus.rx_valid, 1'b0);
    check("abort partial miso", miso_got[0][15:9], exp_hi[15:9]);
    b_abt = n_abt; b_rx = n_rx;
    mw[0] = 16'hC0DE;
    spi_frame(SPI_MODE0, DW, mw, 1'b0);
    check("post-abort miso", miso_got[0], 16'h8888);
    check("post-abort rx", rx_got[b_rx], 16'hC0DE);
    check("post-abort rx count", n_rx - b_rx, 1);
    check("post-abort abort count", n_abt - b_abt, 0);

    // Reset asserted mid-word after 9 bits
    set_tx({16'h0, 16'h0, 16'h0, 16'hFFFF}, 1);
    b_abt = n_abt; b_rx = n_rx; b_und = n_und;
    mw[0] = 16'h1357;
    spi_frame(SPI_MODE0, 9, mw, 1'b1);
    check("pre-rst busy", bus.busy, 1'b1);
    check("pre-rst dout", dout, 1'b1);
    rst = 1'b1;
    #1;
    check("rst busy", bus.busy, 1'b0);
    check("rst dout_oe", dout_oe, 1'b0);
    check("rst dout", dout, 1'b0);
    check("rst rx_valid", bus.rx_valid, 1'b0);
    csb = 1'b1;
    sclk = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    set_tx({16'h0, 16'h0, 16'h2468, 16'h5555}, 2);
    spi_frame(SPI_MODE0, DW, {16'h0, 16'h0, 16'h9ABC}, 1'b0);
    check("post-rst miso", miso_got[0], 16'h5555);
    check("post-rst rx", rx_got[b_rx], 16'h9ABC);
    check("post-rst rx count", n_rx - b_rx, 1);
    check("post-rst abort count", n_abt - b_abt, 0);
    check("post-rst underrun count", n_und - b_und, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- System-clock-synchronous SPI slave; successor to the free-running sclk-domain slave.
- Oversamples sclk, csb and din on clk, so all logic is in one clock domain.
- Supports runtime CPOL/CPHA, any DATA_WIDTH, and multi-word bursts within one csb frame.
- Exchanges words with core logic over valid/ready streams, with underrun, overrun and abort reporting. Sits between the pad ring and register or DMA logic.

Parameters:
DATA_WIDTH, 16, bits per SPI word (4..64), MSB first.
SYNC_STAGES, 2, synchroniser flops on sclk/csb/din (2..4).
UNDERRUN_FILL, 1'b0, bit value replicated into the shifted-out word when no TX data is available.

Ports:
clk  input  1  system clock; must be >= 8x SPI sclk frequency.
rst  input  1  asynchronous, active-high reset.
cpol  input  1  clock polarity; captured at frame start.
cpha  input  1  clock phase; captured at frame start.
sclk  input  1  SPI clock (asynchronous).
csb  input  1  SPI chip select, active low (asynchronous).
din  input  1  MOSI.
dout  output  1  MISO data.
dout_oe  output  1  MISO output enable; high while in ACTIVE.
tx_data  input  DATA_WIDTH  next word to transmit.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  one-cycle pulse; tx_data consumed this cycle.
rx_data  output  DATA_WIDTH  last received word.
rx_valid  output  1  rx_data holds an unconsumed word.
rx_ready  input  1  consumer accepts rx_data.
tx_underrun  output  1  one-cycle pulse; fill word loaded because tx_valid was low.
rx_overrun  output  1  one-cycle pulse; a word completed while rx_valid was still high.
frame_abort  output  1  one-cycle pulse; csb rose with a partial word.
busy  output  1  high while in ACTIVE.

Behaviour:
- Reset: all outputs 0, shift registers 0, bit_cnt 0, state IDLE, synchronisers cleared (csb synchroniser chain resets to 1).
- Synchronise sclk, csb and din through SYNC_STAGES flops.
- Edge detect compares the last sync stage with one extra register.
- Latency from a pin edge to its internal event is SYNC_STAGES+1 clk cycles.
- Edge definitions:
  - leading edge = sclk rising if the captured cpol is 0, falling if it is 1;
  - sample edge = leading edge if cpha=0, trailing edge if cpha=1;
  - shift edge = the opposite edge.
- FSM, two states:
  - IDLE -> ACTIVE on synchronised csb falling. In that same cycle:
    - capture cpol/cpha;
    - bit_cnt=0;
    - load tx_sh from tx_data with tx_ready pulse if tx_valid, else load fill with tx_underrun pulse;
    - first_shift = cpha;
    - load_pending=0.
  - ACTIVE -> IDLE on synchronised csb rising. frame_abort pulses if bit_cnt!=0; the partial RX word is discarded and never presented.
- dout = tx_sh[MSB] at all times; dout_oe = busy.
- Sample edge: rx_sh <= {rx_sh, din_sync}; bit_cnt++. When bit_cnt==DATA_WIDTH-1:
  - next cycle rx_data <= completed word, rx_valid=1;
  - bit_cnt wraps to 0;
  - load_pending=1.
- RX handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears.
  - Word completion while rx_valid is high: overwrite rx_data, keep rx_valid high, pulse rx_overrun.
  - Completion and rx_ready in the same cycle: new word is presented, no overrun.
- Shift edge, checked in priority order:
  1. load_pending: load the next word (same tx_valid/underrun rule as frame start), clear load_pending.
  2. first_shift: clear first_shift, no shift.
  3. Otherwise tx_sh <= tx_sh << 1.
- tx_ready pulses only on a word load; tx_data may change freely at other times.
- csb rising in the same cycle as a sample or shift edge: the csb event wins and the edge is ignored.
- sclk edges while IDLE are ignored.
- cpol/cpha changes during ACTIVE have no effect until the next frame.
- Mid-frame rst: immediate return to IDLE; no pulses generated.
- Trailing shift edge after the last word of a frame (cpha=0) loads a word that is never shifted. That word is consumed (tx_ready pulses) — documented behaviour, software must account for it.

Decomposition:
- Shared package spi_pkg: mode encoding constants (SPI_MODE0..3), helper function for leading/sample edge selection from cpol/cpha.
- One sub-module spi_sync_edge: parametrised SYNC_STAGES synchroniser with rise/fall pulse outputs and configurable reset value. Instantiate it three times (sclk, csb; din uses its sync output only).

Test Plan:
- Mode 0, DATA_WIDTH=16, tx_data=16'hA5C3 valid, master sends 16'h1234 -> master reads 16'hA5C3 on MISO; rx_data=16'h1234, rx_valid=1; one tx_ready pulse at frame start plus one at the word-boundary load.
- Modes 1, 2, 3 each with a 3-word burst (16'h0001, 16'h8000, 16'hFFFF) from the master and TX 16'hDEAD, 16'hBEEF, 16'hCAFE -> all words exchanged bit-exact; 3 rx_valid assertions; no overrun/underrun.
- tx_valid=0 at frame start, UNDERRUN_FILL=1 -> MISO shows 16'hFFFF; tx_underrun pulses once; rx path unaffected.
- rx_ready held 0 across a 2-word burst -> rx_overrun pulses once at the 2nd word completion; rx_data = 2nd word.
- csb rises after 7 bits -> frame_abort pulse; rx_valid stays 0; next full frame received correctly.
- rst asserted mid-word at bit 9 -> all outputs 0 within the same cycle, busy=0; after release and a fresh frame, correct exchange.
